// File: rtl/seg_disp_pkg.sv
// Shared definitions for the front-panel 7-segment scanner.
//   - Active-low segment glyphs, bit order {dp,g,f,e,d,c,b,a}; dp is always off.
//   - digit_glyph(): maps a BCD digit to its glyph. Codes 10..15 map to blank.
//   - conv_state_t: states of the conversion sequencer in the top module.
package seg_disp_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_LOAD  = 2'd1,
        CONV_SHIFT = 2'd2,
        CONV_STORE = 2'd3
    } conv_state_t;

    function automatic logic [7:0] digit_glyph(input logic [3:0] digit);
        logic [7:0] glyph;
        case (digit)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per cycle).
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      request a conversion of bin (accepted only while idle)
//   bin        VAL_W-bit unsigned input, sampled on the accepting edge
//   busy       high while shifting
//   done       one-cycle pulse; bcd holds the result from then until the next start
//   bcd        DIGITS packed BCD digits, digit i at [i*4 +: 4]
// Handshake: start is a request sampled only when busy=0; the edge that sees
// start=1 loads bin, busy rises for VAL_W cycles, then done pulses for one
// cycle, VAL_W+1 cycles after the accepting edge.
// Only DIGITS digits are kept; bits carried out of the top digit are dropped,
// so bcd equals bin mod 10^DIGITS (the caller flags values that do not fit).
module bin2bcd_seq #(
    parameter int VAL_W  = 8,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VAL_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd
);

    localparam int CW = $clog2(VAL_W + 1);

    logic [VAL_W-1:0]    shreg;
    logic [CW-1:0]       cnt;
    logic [DIGITS*4-1:0] adj;

    // Add 3 to every digit >= 5 before the shift so it carries correctly.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                {bcd, shreg} <= {adj, shreg} << 1;
                cnt          <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                shreg <= bin;
                bcd   <= '0;
                cnt   <= CW'(VAL_W);
                busy  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_display_gen.sv
// Time-multiplexed 7-segment scanner for the vending front panel.
// Shows NUM_FIELDS binary values as FIELD_DIGITS decimal digits each, with a
// "-" digit between fields, leading-zero blanking, overflow "E", per-field
// blink and a global enable.
// Ports:
//   sys_clk, sys_rst  clock and synchronous active-high reset
//   disp_en           0 turns every digit off
//   field_val         field f at [f*VAL_W +: VAL_W]
//   blink_mask        1 = field f blinks
//   bit_select        active-low one-hot digit enables, bit 0 = rightmost digit
//   seg_select        active-low {dp,g..a}
//   conv_valid        1 once every field has been converted since reset
module seg_scan_display_gen
    import seg_disp_pkg::*;
#(
    parameter int NUM_FIELDS   = 3,
    parameter int FIELD_DIGITS = 2,
    parameter int VAL_W        = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_DIV    = 64,
    parameter int LZ_BLANK     = 1
) (
    input  logic                                          sys_clk,
    input  logic                                          sys_rst,
    input  logic                                          disp_en,
    input  logic [NUM_FIELDS*VAL_W-1:0]                   field_val,
    input  logic [NUM_FIELDS-1:0]                         blink_mask,
    output logic [NUM_FIELDS*FIELD_DIGITS+NUM_FIELDS-2:0] bit_select,
    output logic [7:0]                                    seg_select,
    output logic                                          conv_valid
);

    localparam int NUM_DIGITS = NUM_FIELDS*FIELD_DIGITS + NUM_FIELDS - 1;
    localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BL_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FI_W  = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int K_W   = $clog2(FIELD_DIGITS + 1);
    localparam int SH_W  = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam int MAX_VAL = 10**FIELD_DIGITS - 1;

    // ---------------- scan prescaler, digit index, blink phase ----------------
    logic [SC_W-1:0]  scan_cnt;
    logic [DIG_W-1:0] digit_idx;
    logic [BL_W-1:0]  blink_cnt;
    logic             blink_phase;
    logic             scan_tick;

    assign scan_tick = (scan_cnt == SC_W'(SCAN_DIV - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            scan_cnt    <= '0;
            digit_idx   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (scan_tick) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + DIG_W'(1);
            if (blink_cnt == BL_W'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BL_W'(1);
            end
        end else begin
            scan_cnt <= scan_cnt + SC_W'(1);
        end
    end

    // ---------------- conversion sequencer ----------------
    conv_state_t                conv_state;
    logic [FI_W-1:0]            field_idx;
    logic [SH_W-1:0]            shift_cnt;
    logic                       ovf_cur;
    logic                       conv_start;
    logic                       conv_busy;
    logic                       conv_done;
    logic [FIELD_DIGITS*4-1:0]  conv_bcd;
    logic [VAL_W-1:0]           cur_val;
    logic [3:0]                 bcd_buf [NUM_FIELDS][FIELD_DIGITS];
    logic [NUM_FIELDS-1:0]      ovf_buf;

    assign cur_val = field_val[field_idx*VAL_W +: VAL_W];

    bin2bcd_seq #(
        .VAL_W  (VAL_W),
        .DIGITS (FIELD_DIGITS)
    ) u_bin2bcd (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .start (conv_start),
        .bin   (cur_val),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // conv_start is high exactly during LOAD, so the converter samples the
    // same field value that LOAD uses for the overflow flag. The buffer is
    // only written in STORE, so a reset mid-conversion leaves nothing partial.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            conv_state <= CONV_IDLE;
            field_idx  <= '0;
            shift_cnt  <= '0;
            ovf_cur    <= 1'b0;
            conv_start <= 1'b0;
            conv_valid <= 1'b0;
            ovf_buf    <= '0;
            for (int f = 0; f < NUM_FIELDS; f++) begin
                for (int k = 0; k < FIELD_DIGITS; k++) begin
                    bcd_buf[f][k] <= 4'd0;
                end
            end
        end else begin
            case (conv_state)
                CONV_IDLE: begin
                    if (!conv_busy) begin
                        conv_state <= CONV_LOAD;
                        conv_start <= 1'b1;
                    end
                end
                CONV_LOAD: begin
                    conv_start <= 1'b0;
                    ovf_cur    <= (32'(cur_val) > 32'(MAX_VAL));
                    shift_cnt  <= '0;
                    conv_state <= CONV_SHIFT;
                end
                CONV_SHIFT: begin
                    if (shift_cnt == SH_W'(VAL_W - 1)) begin
                        conv_state <= CONV_STORE;
                    end else begin
                        shift_cnt <= shift_cnt + SH_W'(1);
                    end
                end
                CONV_STORE: begin
                    if (conv_done) begin
                        for (int k = 0; k < FIELD_DIGITS; k++) begin
                            bcd_buf[field_idx][k] <= conv_bcd[k*4 +: 4];
                        end
                        ovf_buf[field_idx] <= ovf_cur;
                        if (field_idx == FI_W'(NUM_FIELDS - 1)) begin
                            field_idx  <= '0;
                            conv_valid <= 1'b1;
                        end else begin
                            field_idx <= field_idx + FI_W'(1);
                        end
                        conv_state <= CONV_LOAD;
                        conv_start <= 1'b1;
                    end
                end
                default: conv_state <= CONV_IDLE;
            endcase
        end
    end

    // ---------------- glyph selection for the current digit ----------------
    logic [FI_W-1:0] sel_f;
    logic [K_W-1:0]  sel_k;
    logic            is_sep;
    logic [3:0]      cur_digit;
    logic            upper_zero;
    logic [7:0]      glyph_next;

    always_comb begin
        sel_f      = '0;
        sel_k      = '0;
        is_sep     = 1'b0;
        cur_digit  = 4'd0;
        upper_zero = 1'b1;
        glyph_next = SEG_BLANK;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            for (int k = 0; k <= FIELD_DIGITS; k++) begin
                if (int'(digit_idx) == f*(FIELD_DIGITS+1) + k) begin
                    sel_f  = FI_W'(f);
                    sel_k  = K_W'(k);
                    is_sep = (k == FIELD_DIGITS);
                end
            end
        end
        // upper_zero: this digit and every more significant digit of the field are 0.
        for (int j = 0; j < FIELD_DIGITS; j++) begin
            if (j == int'(sel_k)) begin
                cur_digit = bcd_buf[sel_f][j];
            end
            if (j >= int'(sel_k) && bcd_buf[sel_f][j] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        if (is_sep) begin
            glyph_next = SEG_DASH;
        end else if (blink_mask[sel_f] && blink_phase) begin
            glyph_next = SEG_BLANK;
        end else if (ovf_buf[sel_f]) begin
            glyph_next = SEG_E;
        end else if (LZ_BLANK != 0 && sel_k != '0 && upper_zero) begin
            glyph_next = SEG_BLANK;
        end else begin
            glyph_next = digit_glyph(cur_digit);
        end
    end

    // Select and segments come from the same digit_idx in the same register
    // stage, so a digit change never shows the old glyph on the new digit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !disp_en) begin
            bit_select <= '1;
            seg_select <= SEG_BLANK;
        end else begin
            bit_select <= ~(NUM_DIGITS'(1) << digit_idx);
            seg_select <= glyph_next;
        end
    end

endmodule
